// File: rtl/tlb_assoc_array.sv
// tlb_assoc_array: fully-associative TLB with superpages, registered lookup, fill/victim policy and ASID invalidation
module tlb_assoc_array #(
  parameter int ENTRIES    = 16,
  parameter int VPN_WIDTH  = 20,
  parameter int PPN_WIDTH  = 20,
  parameter int ASID_WIDTH = 8,
  parameter int SUPER_BITS = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lookup_valid,
  input  logic [VPN_WIDTH-1:0]          lookup_vpn,
  input  logic [ASID_WIDTH-1:0]         lookup_asid,
  output logic                          resp_valid,
  output logic                          resp_hit,
  output logic [PPN_WIDTH-1:0]          resp_ppn,
  output logic [3:0]                    resp_flags,
  output logic                          resp_super,
  input  logic                          write_en,
  input  logic [VPN_WIDTH-1:0]          write_vpn,
  input  logic [PPN_WIDTH-1:0]          write_ppn,
  input  logic [ASID_WIDTH-1:0]         write_asid,
  input  logic [3:0]                    write_flags,
  input  logic                          write_global,
  input  logic                          write_super,
  input  logic [1:0]                    inv_op,
  input  logic [VPN_WIDTH-1:0]          inv_vpn,
  input  logic [ASID_WIDTH-1:0]         inv_asid,
  output logic [$clog2(ENTRIES):0]      occupancy
);
  localparam int IW = $clog2(ENTRIES);
  localparam int OW = IW + 1;
  localparam logic [VPN_WIDTH-1:0] VMASK = {VPN_WIDTH{1'b1}} << SUPER_BITS;
  localparam logic [PPN_WIDTH-1:0] PMASK = {PPN_WIDTH{1'b1}} << SUPER_BITS;

  logic [ENTRIES-1:0]    valid_q, valid_d, global_q, global_d, super_q, super_d;
  logic [VPN_WIDTH-1:0]  vpn_q [ENTRIES];
  logic [VPN_WIDTH-1:0]  vpn_d [ENTRIES];
  logic [PPN_WIDTH-1:0]  ppn_q [ENTRIES];
  logic [PPN_WIDTH-1:0]  ppn_d [ENTRIES];
  logic [ASID_WIDTH-1:0] asid_q [ENTRIES];
  logic [ASID_WIDTH-1:0] asid_d [ENTRIES];
  logic [3:0]            flags_q [ENTRIES];
  logic [3:0]            flags_d [ENTRIES];
  logic [IW-1:0]         victim_q, victim_d, lk_idx, wr_idx;
  logic [OW-1:0]         occ_q, occ_d;
  logic                  resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d, resp_super_q, resp_super_d;
  logic [PPN_WIDTH-1:0]  resp_ppn_q, resp_ppn_d;
  logic [3:0]            resp_flags_q, resp_flags_d;
  logic [ENTRIES-1:0]    lk_m, wr_m, inv_m;
  logic                  lk_hit, wr_hit, wr_free;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign lk_m[g] = valid_q[g] && (global_q[g] || asid_q[g] == lookup_asid) &&
                     ((vpn_q[g] ^ lookup_vpn) & (super_q[g] ? VMASK : '1)) == '0;
    assign wr_m[g] = valid_q[g] && (write_global || asid_q[g] == write_asid) &&
                     ((vpn_q[g] ^ write_vpn) & (write_super ? VMASK : '1)) == '0;
    assign inv_m[g] = inv_op == 2'b11 ? valid_q[g] :
                      inv_op == 2'b10 ? valid_q[g] && !global_q[g] && asid_q[g] == inv_asid :
                      valid_q[g] && (global_q[g] || asid_q[g] == inv_asid) &&
                      ((vpn_q[g] ^ inv_vpn) & (super_q[g] ? VMASK : '1)) == '0;
  end

  // lowest-index selection: lookup winner and write slot (match, then free, then victim)
  always_comb begin
    lk_hit = |lk_m;
    wr_hit = |wr_m;
    wr_free = ~&valid_q;
    lk_idx = '0;
    wr_idx = victim_q;
    for (int i = ENTRIES - 1; i >= 0; i--) if (!valid_q[i]) wr_idx = IW'(i);
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (wr_m[i]) wr_idx = IW'(i);
      if (lk_m[i]) lk_idx = IW'(i);
    end
  end

  // array update (invalidate beats write), occupancy and registered response
  always_comb begin
    valid_d = valid_q;
    global_d = global_q;
    super_d = super_q;
    vpn_d = vpn_q;
    ppn_d = ppn_q;
    asid_d = asid_q;
    flags_d = flags_q;
    victim_d = victim_q;
    if (inv_op != 2'b00) valid_d = valid_q & ~inv_m;
    else if (write_en) begin
      valid_d[wr_idx] = 1'b1;
      global_d[wr_idx] = write_global;
      super_d[wr_idx] = write_super;
      vpn_d[wr_idx] = write_vpn;
      ppn_d[wr_idx] = write_ppn;
      asid_d[wr_idx] = write_asid;
      flags_d[wr_idx] = write_flags;
      victim_d = (wr_hit || wr_free) ? victim_q : victim_q + IW'(1);
    end
    occ_d = '0;
    for (int i = 0; i < ENTRIES; i++) occ_d = occ_d + OW'(valid_d[i]);
    resp_valid_d = lookup_valid;
    resp_hit_d = lookup_valid && lk_hit;
    resp_super_d = resp_hit_d && super_q[lk_idx];
    resp_flags_d = resp_hit_d ? flags_q[lk_idx] : 4'b0;
    resp_ppn_d = !resp_hit_d ? '0 :
                 super_q[lk_idx] ? (ppn_q[lk_idx] & PMASK) | (PPN_WIDTH'(lookup_vpn[SUPER_BITS-1:0]) & ~PMASK) :
                 ppn_q[lk_idx];
  end

  // control state and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      victim_q <= '0;
      occ_q <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q <= 1'b0;
      resp_super_q <= 1'b0;
      resp_flags_q <= '0;
      resp_ppn_q <= '0;
    end else begin
      valid_q <= valid_d;
      victim_q <= victim_d;
      occ_q <= occ_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q <= resp_hit_d;
      resp_super_q <= resp_super_d;
      resp_flags_q <= resp_flags_d;
      resp_ppn_q <= resp_ppn_d;
    end
  end

  // entry payload, only meaningful where valid is set
  always_ff @(posedge clk) begin
    global_q <= global_d;
    super_q <= super_d;
    vpn_q <= vpn_d;
    ppn_q <= ppn_d;
    asid_q <= asid_d;
    flags_q <= flags_d;
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit = resp_hit_q;
  assign resp_ppn = resp_ppn_q;
  assign resp_flags = resp_flags_q;
  assign resp_super = resp_super_q;
  assign occupancy = occ_q;
endmodule

// File: doc/tlb_assoc_array.md
Name: tlb_assoc_array

Overview:
Parametrised, fully-associative TLB array. It is the successor to the single-entry TLB cell and is what the MMU instantiates in place of a bank of discrete entries. It adds configurable depth, superpage entries, a registered 1-cycle lookup, a built-in fill/victim policy, and invalidate-by-ASID. It sits between the MMU lookup front end and the page-table walker refill path.

Parameters:
ENTRIES, 16, number of entries (power of 2, 2..64)
VPN_WIDTH, 20, virtual page number width
PPN_WIDTH, 20, physical page number width
ASID_WIDTH, 8, address-space ID width
SUPER_BITS, 10, low VPN/PPN bits ignored or passed through for superpage entries (< VPN_WIDTH, <= PPN_WIDTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
lookup_valid  in  1  lookup request this cycle
lookup_vpn  in  VPN_WIDTH  VPN to translate
lookup_asid  in  ASID_WIDTH  current ASID
resp_valid  out  1  registered: lookup_valid from previous cycle
resp_hit  out  1  registered hit
resp_ppn  out  PPN_WIDTH  translated PPN, superpage low bits merged
resp_flags  out  4  R,W,X,U of hit entry
resp_super  out  1  hit entry is a superpage
write_en  in  1  refill request
write_vpn  in  VPN_WIDTH  refill VPN
write_ppn  in  PPN_WIDTH  refill PPN
write_asid  in  ASID_WIDTH  refill ASID
write_flags  in  4  refill RWXU
write_global  in  1  refill global bit
write_super  in  1  refill is a superpage
inv_op  in  2  00 none, 01 by VPN+ASID, 10 by ASID (non-global), 11 all
inv_vpn  in  VPN_WIDTH  invalidate VPN (op 01)
inv_asid  in  ASID_WIDTH  invalidate ASID (ops 01, 10)
occupancy  out  $clog2(ENTRIES)+1  count of valid entries

Behaviour:
- Reset (rst=1 at edge): all entry valid bits 0, victim pointer 0, resp_valid=0, resp_hit=0, resp_ppn=0, resp_flags=0, resp_super=0, occupancy=0. Reset overrides all other inputs that cycle.
- Match for entry i: valid && (global || asid==req_asid) && VPN compare. The VPN compare covers all bits, except that bits [SUPER_BITS-1:0] are ignored when the entry is super.
- Lookup: 1-cycle latency. Compare uses the array state before the edge, so a same-cycle write or invalidate is not visible. On the next cycle resp_valid=lookup_valid and resp_hit=lookup_valid && any match.
- Hit data: resp_ppn = entry ppn. For a super entry, resp_ppn[SUPER_BITS-1:0] = lookup_vpn[SUPER_BITS-1:0] from the request.
- Miss or no request: resp_hit=0, resp_ppn/flags/super=0.
- Multiple matches: cannot arise through the write rules below. If they do, the lowest index wins.
- Write slot selection, in priority order:
  1. Lowest-index entry matching write_vpn/write_asid under the lookup rules, using the write entry's own super/global mask (overwrite in place).
  2. Otherwise, the lowest-index invalid entry.
  3. Otherwise, the victim pointer; the pointer then increments modulo ENTRIES. It advances only on case 3.
- Write stores all fields and sets valid=1. occupancy increments only in case 2.
- Invalidate has priority over write. If inv_op!=00 and write_en=1 in the same cycle, the write is dropped entirely.
  - op 01: clears every entry matching inv_vpn/inv_asid (global entries match any ASID, super masks apply).
  - op 10: clears every non-global entry with asid==inv_asid.
  - op 11: clears all entries.
- Invalidation does not move the victim pointer. occupancy drops by the number of entries cleared, computed as a popcount of the valid bits registered each cycle.
- Lookup and invalidate in the same cycle: the response reflects the pre-invalidate state.

Test Plan:
- Reset then lookup vpn 0x12345, asid 1 -> next cycle resp_valid=1, resp_hit=0, occupancy=0.
- Write vpn 0x00010→ppn 0xABCDE, asid 3, flags 1011. Lookup same vpn in the same cycle -> miss. Lookup next cycle -> hit, ppn 0xABCDE, flags 1011. Lookup with asid 4 -> miss; same with global=1 -> hit.
- Super write vpn 0x40000→ppn 0x80000. Lookup vpn 0x403FF -> hit, resp_ppn 0x803FF, resp_super=1. Lookup vpn 0x40400 -> miss.
- Fill 16 distinct VPNs (occupancy 16), then write 3 more -> entries 0,1,2 replaced in order. Old VPNs 0–2 miss, occupancy stays 16. Rewrite an existing VPN -> updated in place, pointer unchanged.
- Load asid 5 non-global x4, asid 5 global x1, asid 6 x2. Apply inv_op=10 with asid 5 -> occupancy 7→3; the global entry still hits.
- inv_op=11 with write_en=1 in the same cycle -> all lookups miss, occupancy 0. Assert rst mid-fill -> outputs zero on the next cycle.
